// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer between the Ethernet MAC and the protocol layer.
// The MAC writes whole frames into fixed 2048-byte slots. Each slot starts
// with a two-byte length header. This block tracks slot occupancy, drives MAC
// back-pressure, and streams each buffered frame out over valid/ready.
module eth_rx_frame_buf #(
    parameter int unsigned SLOTS  = 2,
    parameter int unsigned SLOT_W = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en_in,
    input  logic [10:0] wr_addr_in,
    input  logic [7:0]  wr_d_in,
    input  logic        done_in,
    output logic        full_out,
    output logic        rd_valid_out,
    input  logic        rd_ready_in,
    output logic [7:0]  rd_d_out,
    output logic        rd_sof_out,
    output logic        rd_eof_out,
    output logic [10:0] rd_len_out,
    input  logic        drop_in,
    output logic        bad_len_out
);

    localparam int unsigned OFF_W   = 11;
    localparam int unsigned ADDR_W  = SLOT_W + OFF_W;
    localparam int unsigned DEPTH   = SLOTS << OFF_W;
    localparam int unsigned CNT_W   = SLOT_W + 1;
    localparam int unsigned MAX_LEN = 2045;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_CHECK,
        ST_STREAM,
        ST_RELEASE
    } state_e;

    logic [7:0]        mem [DEPTH];

    state_e            state_q,   state_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              full_q,    full_d;
    logic [2:0]        len_hi_q,  len_hi_d;
    logic [OFF_W-1:0]  len_q,     len_d;
    logic [OFF_W-1:0]  idx_q,     idx_d;
    logic              valid_q,   valid_d;
    logic              sof_q,     sof_d;
    logic              eof_q,     eof_d;
    logic              bad_len_q, bad_len_d;
    logic [7:0]        ram_q;

    logic              inc_c;
    logic              dec_c;
    logic              re_c;
    logic [OFF_W-1:0]  roff_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [ADDR_W-1:0] raddr_c;

    assign waddr_c = {wr_slot_q, wr_addr_in};
    assign raddr_c = {rd_slot_q, roff_c};

    assign full_out     = full_q;
    assign rd_valid_out = valid_q;
    assign rd_d_out     = ram_q;
    assign rd_sof_out   = sof_q;
    assign rd_eof_out   = eof_q;
    assign rd_len_out   = len_q;
    assign bad_len_out  = bad_len_q;

    // Byte RAM write port, addressed by the MAC within the current write slot
    always_ff @(posedge clk) begin
        if (wr_en_in) begin
            mem[waddr_c] <= wr_d_in;
        end
    end

    // Registered read port; holding the enable low keeps the presented byte stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q <= '0;
        end else if (re_c) begin
            ram_q <= mem[raddr_c];
        end
    end

    // Occupancy: a done while full is dropped; done plus release cancels out
    always_comb begin
        inc_c     = done_in && (count_q != CNT_W'(SLOTS));
        wr_slot_d = inc_c ? wr_slot_q + SLOT_W'(1) : wr_slot_q;
        count_d   = count_q + CNT_W'(inc_c) - CNT_W'(dec_c);
        full_d    = (count_d == CNT_W'(SLOTS));
    end

    // Read sequencer: header fetch, length check, byte streaming, slot release
    always_comb begin
        state_d   = state_q;
        rd_slot_d = rd_slot_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        bad_len_d = 1'b0;
        re_c      = 1'b0;
        roff_c    = '0;
        dec_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    re_c    = 1'b1;
                    roff_c  = OFF_W'(0);
                    state_d = ST_HDR0;
                end
            end
            ST_HDR0: begin
                len_hi_d = ram_q[2:0];
                re_c     = 1'b1;
                roff_c   = OFF_W'(1);
                state_d  = ST_HDR1;
            end
            ST_HDR1: begin
                len_d   = {len_hi_q, ram_q};
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if ((len_q == '0) || (len_q > OFF_W'(MAX_LEN))) begin
                    bad_len_d = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    re_c    = 1'b1;
                    roff_c  = OFF_W'(3);
                    idx_d   = '0;
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    eof_d   = (len_q == OFF_W'(1));
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (drop_in) begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eof_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (valid_q && rd_ready_in) begin
                    if (eof_q) begin
                        valid_d = 1'b0;
                        sof_d   = 1'b0;
                        eof_d   = 1'b0;
                        state_d = ST_RELEASE;
                    end else begin
                        // Frame byte k lives at offset 3+k, so the next byte is idx+4
                        re_c   = 1'b1;
                        roff_c = idx_q + OFF_W'(4);
                        idx_d  = idx_q + OFF_W'(1);
                        sof_d  = 1'b0;
                        eof_d  = ((idx_q + OFF_W'(2)) == len_q);
                    end
                end
            end
            ST_RELEASE: begin
                rd_slot_d = rd_slot_q + SLOT_W'(1);
                dec_c     = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            len_hi_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            bad_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            count_q   <= count_d;
            full_q    <= full_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            bad_len_q <= bad_len_d;
        end
    end

endmodule
